// File: rtl/bit32_1to4_demux_if.sv
// Bus bundle for the 1:4 demultiplexer: input word handshake, channel selects,
// and the four per-channel output handshakes.
interface bit32_1to4_demux_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             sel1;
  logic             sel2;
  logic             rr_mode;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic [WIDTH-1:0] out3;
  logic [WIDTH-1:0] out4;
  logic             valid1;
  logic             valid2;
  logic             valid3;
  logic             valid4;
  logic             ready1;
  logic             ready2;
  logic             ready3;
  logic             ready4;
  logic [7:0]       xfer_count;

  modport master (
    output in_data, in_valid, sel1, sel2, rr_mode,
    output ready1, ready2, ready3, ready4,
    input  in_ready, xfer_count,
    input  out1, out2, out3, out4,
    input  valid1, valid2, valid3, valid4
  );

  modport slave (
    input  in_data, in_valid, sel1, sel2, rr_mode,
    input  ready1, ready2, ready3, ready4,
    output in_ready, xfer_count,
    output out1, out2, out3, out4,
    output valid1, valid2, valid3, valid4
  );
endinterface

// File: rtl/bit32_1to4_demux.sv
// 1:4 demultiplexer with a one-word buffer per channel, routing by explicit
// select or by an internal round-robin pointer, plus an accepted-word counter.
module bit32_1to4_demux #(
  parameter int WIDTH = 32
) (
  input logic                     clk,
  input logic                     reset,
  bit32_1to4_demux_if.slave       bus
);

  logic [WIDTH-1:0] data_q [4];
  logic [3:0]       valid_q;
  logic [3:0]       ready_v;
  logic [3:0]       load;
  logic [1:0]       rr_ptr;
  logic [1:0]       target;
  logic [7:0]       xfer_count_q;
  logic             in_ready_c;
  logic             accept;

  assign ready_v = {bus.ready4, bus.ready3, bus.ready2, bus.ready1};

  // A target buffer can take a word if it is empty or being drained this cycle.
  always_comb begin
    target     = bus.rr_mode ? rr_ptr : {bus.sel2, bus.sel1};
    in_ready_c = !valid_q[target] || ready_v[target];
    accept     = bus.in_valid && in_ready_c;
    load       = 4'b0000;
    if (accept) begin
      load = 4'b0001 << target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        valid_q[i] <= load[i] || (valid_q[i] && !ready_v[i]);
        if (load[i]) begin
          data_q[i] <= bus.in_data;
        end
      end
    end
  end

  // The pointer is kept across mode changes so round-robin resumes where it left off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr       <= 2'd0;
      xfer_count_q <= 8'd0;
    end else if (accept) begin
      xfer_count_q <= xfer_count_q + 8'd1;
      if (bus.rr_mode) begin
        rr_ptr <= rr_ptr + 2'd1;
      end
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.xfer_count = xfer_count_q;
  assign bus.out1       = data_q[0];
  assign bus.out2       = data_q[1];
  assign bus.out3       = data_q[2];
  assign bus.out4       = data_q[3];
  assign bus.valid1     = valid_q[0];
  assign bus.valid2     = valid_q[1];
  assign bus.valid3     = valid_q[2];
  assign bus.valid4     = valid_q[3];

endmodule

// File: tb/tb_bit32_1to4_demux.sv
// Directed bench for bit32_1to4_demux: a table of single-cycle vectors followed
// by hand-written backpressure, mid-operation reset and counter-wrap sequences.
module tb_bit32_1to4_demux;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checkCount = 0;
  int   passCount = 0;

  bit32_1to4_demux_if #(.WIDTH(32)) bus ();

  bit32_1to4_demux #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         rr;
    logic [1:0]   sel;
    logic         v;
    logic [3:0]   rdy;
    logic [31:0]  data;
    logic         exp_ready;
    logic [3:0]   exp_valid;
    logic [7:0]   exp_xfer;
    logic [127:0] exp_outs;
  } vec_t;

  vec_t tbl [18];

  function automatic logic [3:0] validVec();
    return {bus.valid4, bus.valid3, bus.valid2, bus.valid1};
  endfunction

  function automatic logic [127:0] outsVec();
    return {bus.out4, bus.out3, bus.out2, bus.out1};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rr, input logic [1:0] sel, input logic v,
                               input logic [3:0] rdy, input logic [31:0] data);
    bus.rr_mode  = rr;
    bus.sel2     = sel[1];
    bus.sel1     = sel[0];
    bus.in_valid = v;
    bus.ready4   = rdy[3];
    bus.ready3   = rdy[2];
    bus.ready2   = rdy[1];
    bus.ready1   = rdy[0];
    bus.in_data  = data;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Watchdog so a broken clock or stuck sequence still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int stalls;

    tbl[0]  = '{1'b0, 2'b01, 1'b1, 4'b0000, 32'hAAAAAAAA, 1'b1, 4'b0010, 8'd1,
                {32'h0, 32'h0, 32'hAAAAAAAA, 32'h0}};
    tbl[1]  = '{1'b0, 2'b01, 1'b1, 4'b0000, 32'h11111111, 1'b0, 4'b0010, 8'd1,
                {32'h0, 32'h0, 32'hAAAAAAAA, 32'h0}};
    tbl[2]  = '{1'b0, 2'b01, 1'b1, 4'b0010, 32'h11111111, 1'b1, 4'b0010, 8'd2,
                {32'h0, 32'h0, 32'h11111111, 32'h0}};
    tbl[3]  = '{1'b0, 2'b10, 1'b1, 4'b0000, 32'h33333333, 1'b1, 4'b0110, 8'd3,
                {32'h0, 32'h33333333, 32'h11111111, 32'h0}};
    tbl[4]  = '{1'b0, 2'b11, 1'b1, 4'b0000, 32'h44444444, 1'b1, 4'b1110, 8'd4,
                {32'h44444444, 32'h33333333, 32'h11111111, 32'h0}};
    tbl[5]  = '{1'b0, 2'b00, 1'b0, 4'b1000, 32'h0, 1'b1, 4'b0110, 8'd4,
                {32'h44444444, 32'h33333333, 32'h11111111, 32'h0}};
    tbl[6]  = '{1'b0, 2'b00, 1'b0, 4'b0110, 32'h0, 1'b1, 4'b0000, 8'd4,
                {32'h44444444, 32'h33333333, 32'h11111111, 32'h0}};
    tbl[7]  = '{1'b0, 2'b00, 1'b1, 4'b0001, 32'h55555555, 1'b1, 4'b0001, 8'd5,
                {32'h44444444, 32'h33333333, 32'h11111111, 32'h55555555}};
    tbl[8]  = '{1'b0, 2'b00, 1'b0, 4'b0000, 32'h0, 1'b0, 4'b0001, 8'd5,
                {32'h44444444, 32'h33333333, 32'h11111111, 32'h55555555}};
    tbl[9]  = '{1'b1, 2'b11, 1'b1, 4'b1111, 32'h1, 1'b1, 4'b0001, 8'd6,
                {32'h44444444, 32'h33333333, 32'h11111111, 32'h1}};
    tbl[10] = '{1'b1, 2'b11, 1'b1, 4'b1111, 32'h2, 1'b1, 4'b0010, 8'd7,
                {32'h44444444, 32'h33333333, 32'h2, 32'h1}};
    tbl[11] = '{1'b1, 2'b00, 1'b1, 4'b1111, 32'h3, 1'b1, 4'b0100, 8'd8,
                {32'h44444444, 32'h3, 32'h2, 32'h1}};
    tbl[12] = '{1'b1, 2'b01, 1'b1, 4'b1111, 32'h4, 1'b1, 4'b1000, 8'd9,
                {32'h4, 32'h3, 32'h2, 32'h1}};
    tbl[13] = '{1'b1, 2'b10, 1'b1, 4'b1111, 32'h5, 1'b1, 4'b0001, 8'd10,
                {32'h4, 32'h3, 32'h2, 32'h5}};
    tbl[14] = '{1'b0, 2'b11, 1'b1, 4'b0000, 32'h66, 1'b1, 4'b1001, 8'd11,
                {32'h66, 32'h3, 32'h2, 32'h5}};
    tbl[15] = '{1'b1, 2'b00, 1'b1, 4'b0000, 32'h77, 1'b1, 4'b1011, 8'd12,
                {32'h66, 32'h3, 32'h77, 32'h5}};
    tbl[16] = '{1'b1, 2'b00, 1'b1, 4'b0000, 32'h88, 1'b1, 4'b1111, 8'd13,
                {32'h66, 32'h88, 32'h77, 32'h5}};
    tbl[17] = '{1'b1, 2'b00, 1'b1, 4'b0000, 32'h99, 1'b0, 4'b1111, 8'd13,
                {32'h66, 32'h88, 32'h77, 32'h5}};

    // Reset state is visible without any clock edge.
    applyStimulus(1'b0, 2'b00, 1'b0, 4'b0000, 32'h0);
    #2;
    checkOutput("reset_valid", {124'h0, validVec()}, 128'h0);
    checkOutput("reset_outs", outsVec(), 128'h0);
    checkOutput("reset_xfer", {120'h0, bus.xfer_count}, 128'h0);
    checkOutput("reset_in_ready", {127'h0, bus.in_ready}, 128'h1);
    step();
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      applyStimulus(tbl[i].rr, tbl[i].sel, tbl[i].v, tbl[i].rdy, tbl[i].data);
      #1;
      checkOutput($sformatf("vec%0d_in_ready", i), {127'h0, bus.in_ready}, {127'h0, tbl[i].exp_ready});
      step();
      checkOutput($sformatf("vec%0d_valid", i), {124'h0, validVec()}, {124'h0, tbl[i].exp_valid});
      checkOutput($sformatf("vec%0d_xfer", i), {120'h0, bus.xfer_count}, {120'h0, tbl[i].exp_xfer});
      checkOutput($sformatf("vec%0d_outs", i), outsVec(), tbl[i].exp_outs);
    end

    // Backpressure on a full channel 3, then release with a same-cycle accept.
    applyStimulus(1'b0, 2'b00, 1'b0, 4'b0000, 32'h0);
    pulseReset();
    applyStimulus(1'b0, 2'b10, 1'b1, 4'b0000, 32'hCAFE0001);
    step();
    applyStimulus(1'b0, 2'b10, 1'b1, 4'b0000, 32'hCAFE0002);
    for (int c = 0; c < 5; c++) begin
      #1;
      checkOutput($sformatf("bp%0d_in_ready", c), {127'h0, bus.in_ready}, 128'h0);
      step();
      checkOutput($sformatf("bp%0d_out3", c), {96'h0, bus.out3}, {96'h0, 32'hCAFE0001});
      checkOutput($sformatf("bp%0d_valid", c), {124'h0, validVec()}, {124'h0, 4'b0100});
    end
    applyStimulus(1'b0, 2'b10, 1'b1, 4'b0100, 32'hCAFE0002);
    #1;
    checkOutput("bp_release_in_ready", {127'h0, bus.in_ready}, 128'h1);
    step();
    checkOutput("bp_release_out3", {96'h0, bus.out3}, {96'h0, 32'hCAFE0002});
    checkOutput("bp_release_valid", {124'h0, validVec()}, {124'h0, 4'b0100});
    checkOutput("bp_release_xfer", {120'h0, bus.xfer_count}, {120'h0, 8'd2});

    // Fill all channels, then assert reset between clock edges.
    applyStimulus(1'b0, 2'b00, 1'b0, 4'b0000, 32'h0);
    pulseReset();
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, c[1:0], 1'b1, 4'b0000, 32'hD0 + c);
      step();
    end
    checkOutput("mid_pre_xfer", {120'h0, bus.xfer_count}, {120'h0, 8'd4});
    checkOutput("mid_pre_valid", {124'h0, validVec()}, {124'h0, 4'b1111});
    applyStimulus(1'b0, 2'b00, 1'b0, 4'b0000, 32'h0);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_valid", {124'h0, validVec()}, 128'h0);
    checkOutput("mid_rst_outs", outsVec(), 128'h0);
    checkOutput("mid_rst_xfer", {120'h0, bus.xfer_count}, 128'h0);
    checkOutput("mid_rst_in_ready", {127'h0, bus.in_ready}, 128'h1);
    step();
    checkOutput("mid_rst_hold_in_ready", {127'h0, bus.in_ready}, 128'h1);
    reset = 1'b0;
    applyStimulus(1'b0, 2'b01, 1'b1, 4'b0000, 32'hBEEF);
    step();
    checkOutput("post_rst_xfer", {120'h0, bus.xfer_count}, {120'h0, 8'd1});
    checkOutput("post_rst_valid", {124'h0, validVec()}, {124'h0, 4'b0010});
    checkOutput("post_rst_out2", {96'h0, bus.out2}, {96'h0, 32'hBEEF});

    // 256 back-to-back accepts into a continuously drained channel.
    applyStimulus(1'b0, 2'b00, 1'b0, 4'b1111, 32'h0);
    pulseReset();
    stalls = 0;
    for (int c = 0; c < 256; c++) begin
      applyStimulus(1'b0, 2'b00, 1'b1, 4'b1111, c);
      #1;
      if (bus.in_ready !== 1'b1) stalls++;
      step();
      if (c == 254) begin
        checkOutput("wrap_xfer_255", {120'h0, bus.xfer_count}, {120'h0, 8'd255});
      end
    end
    checkOutput("wrap_stalls", 128'(stalls), 128'h0);
    checkOutput("wrap_xfer_0", {120'h0, bus.xfer_count}, 128'h0);
    checkOutput("wrap_out1", {96'h0, bus.out1}, {96'h0, 32'd255});
    applyStimulus(1'b0, 2'b00, 1'b0, 4'b1111, 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/bit32_1to4_demux.md
BIT32_1TO4_DEMUX -- requirements
Module: bit32_1to4_demux

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of the input word and of each output channel.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_data  input  WIDTH  word to be routed.
REQ-005 SHALL have port in_valid  input  1  in_data is presented for transfer.
REQ-006 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-007 SHALL have port sel1  input  1  channel select, low bit.
REQ-008 SHALL have port sel2  input  1  channel select, high bit.
REQ-009 SHALL have port rr_mode  input  1  0 = route by sel2:sel1, 1 = route by internal round-robin pointer.
REQ-010 SHALL have ports out1..out4  output  WIDTH each  per-channel held data.
REQ-011 SHALL have ports valid1..valid4  output  1 each  channel holds an undelivered word.
REQ-012 SHALL have ports ready1..ready4  input  1 each  consumer of that channel takes the word this cycle.
REQ-013 SHALL have port xfer_count  output  8  number of accepted input words, modulo 256.

Function
REQ-014 SHALL define channel index as {sel2,sel1}: 00 -> ch1, 01 -> ch2, 10 -> ch3, 11 -> ch4 (same select encoding as the 4:1 selector).
REQ-015 SHALL use target = rr_ptr when rr_mode=1, else {sel2,sel1}; target is evaluated combinationally in the accepting cycle.
REQ-016 SHALL hold one-entry buffer per channel: data register outN and flag validN.
REQ-017 SHALL drive in_ready = !valid[target] | ready[target] (buffer empty or draining this cycle); in_ready never depends on in_valid.
REQ-018 SHALL accept when in_valid & in_ready; on accept, outN[target] <= in_data and validN[target] <= 1 at that edge (latency 1 cycle, data visible the cycle after accept).
REQ-019 SHALL clear validN at the edge where validN & readyN and channel N is not loaded the same edge.
REQ-020 SHALL, on simultaneous drain and load of the same channel, load the new word and keep validN=1 (no bubble).
REQ-021 SHALL hold outN stable while validN & !readyN; outN unchanged when not loaded (retains last word after drain).
REQ-022 SHALL never load more than one channel per cycle; non-target channels drain independently of input activity.
REQ-023 SHALL advance 2-bit rr_ptr by 1 on each accept when rr_mode=1, wrapping 3 -> 0; no advance without accept or when rr_mode=0.
REQ-024 SHALL retain rr_ptr across rr_mode changes; a mode change applies to the next accept.
REQ-025 SHALL allow sel1/sel2 to change every cycle; only the value in the accepting cycle matters.
REQ-026 SHALL increment xfer_count on every accept, wrapping 255 -> 0.
REQ-027 SHALL stall input (in_ready=0) when target buffer full and its readyN=0, with no data loss and no state change for that channel.

Reset
REQ-028 SHALL, while reset=1 (asynchronously, regardless of clk), force valid1..4=0, out1..4=0, rr_ptr=0, xfer_count=0.
REQ-029 SHALL drop any undelivered buffered word when reset asserts mid-operation; in_ready SHALL be 1 during and after reset.
REQ-030 SHALL resume normal operation at the first rising edge after reset deasserts.

Verification
REQ-031 Explicit route: rr_mode=0, sel2:sel1=01, in_data=32'hAAAAAAAA, in_valid 1 cycle, all ready=0 -> next cycle out2=32'hAAAAAAAA, valid2=1, others valid=0, xfer_count=1.
REQ-032 Backpressure: ch3 full, ready3=0, sel2:sel1=10, in_valid=1 -> in_ready=0, out3 unchanged for 5 cycles; raise ready3 -> accept same cycle, out3 = new word next cycle, valid3 stays 1.
REQ-033 Round robin: rr_mode=1, ready all 1, 5 accepts 32'h1..32'h5 -> ch1=1, ch2=2, ch3=3, ch4=4, ch1=5 (wrap), rr_ptr=1 at end.
REQ-034 Drain: valid4=1, ready4=1, no input -> valid4=0 next cycle, out4 retains last value.
REQ-035 Reset mid-operation: all four channels valid, xfer_count=4, assert reset between clock edges -> immediately valid1..4=0, out1..4=0, xfer_count=0.
REQ-036 Counter wrap: 256 back-to-back accepts with ready all 1 -> xfer_count returns to 0, no stall cycles.
